// File: rtl/lbp_pkg.sv
// Shared types and sizes for the LBP histogram block.
// Bin counters and the running total share one width (CNT_W_DEF).
package lbp_pkg;

  localparam int CNT_W_DEF = 14;
  localparam int BIN_N     = 256;
  localparam int IDX_W     = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lbp_histogram_if.sv
// Histogram drain stream: one beat per bin, valid/ready handshake.
interface lbp_histogram_if #(
  parameter int CNT_W = lbp_pkg::CNT_W_DEF
) ();

  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic             hist_last;

  modport master (
    output hist_valid,
    output hist_bin,
    output hist_count,
    output hist_last,
    input  hist_ready
  );

  modport slave (
    input  hist_valid,
    input  hist_bin,
    input  hist_count,
    input  hist_last,
    output hist_ready
  );

endinterface

// File: rtl/lbp_hist_bank.sv
// 256 saturating bin counters with one increment port and one
// combinational read port that clears the addressed bin when told to.
module lbp_hist_bank
  import lbp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data
);

  logic [BIN_N*CNT_W-1:0] bins_flat;

  generate
    for (genvar gi = 0; gi < BIN_N; gi++) begin : g_bin
      logic [CNT_W-1:0] cnt_d;
      logic [CNT_W-1:0] cnt_q;
      logic             inc_hit;
      logic             clr_hit;

      assign inc_hit = inc_en && (inc_idx == IDX_W'(gi));
      assign clr_hit = clr_en && (rd_idx == IDX_W'(gi));

      // Increment and clear never coincide: they come from exclusive states.
      always_comb begin
        cnt_d = cnt_q;
        if (inc_hit && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (clr_hit) begin
          cnt_d = '0;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign bins_flat[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

  assign rd_data = bins_flat[int'(rd_idx)*CNT_W +: CNT_W];

endmodule

// File: rtl/lbp_histogram.sv
// Accumulates a per-frame histogram of LBP codes, then drains and
// clears the bins in order over a valid/ready stream.
module lbp_histogram
  import lbp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lbp_valid,
  input  logic [7:0]            lbp_data,
  input  logic                  finish,
  lbp_histogram_if.master       hist,
  output logic [CNT_W-1:0]      total,
  output logic                  done
);

  state_t           state_d, state_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic [CNT_W-1:0] total_d, total_q;
  logic             finish_prev_d, finish_prev_q;
  logic             accept;
  logic             clr_en;
  logic [CNT_W-1:0] rd_data;

  assign finish_prev_d = finish;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    total_d = total_q;
    accept  = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      ACCUM: begin
        if (finish && !finish_prev_q) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else if (lbp_valid && !finish) begin
          accept = 1'b1;
          if (total_q != {CNT_W{1'b1}}) begin
            total_d = total_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (hist.hist_ready) begin
          clr_en = 1'b1;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(BIN_N - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!finish) begin
          state_d = ACCUM;
          total_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // The edge register resets high so a finish already high out of reset
  // is not mistaken for a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ACCUM;
      idx_q         <= '0;
      total_q       <= '0;
      finish_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      total_q       <= total_d;
      finish_prev_q <= finish_prev_d;
    end
  end

  lbp_hist_bank #(
    .CNT_W (CNT_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (accept),
    .inc_idx (lbp_data),
    .clr_en  (clr_en),
    .rd_idx  (idx_q),
    .rd_data (rd_data)
  );

  assign hist.hist_valid = (state_q == DRAIN);
  assign hist.hist_bin   = (state_q == DRAIN) ? idx_q : '0;
  assign hist.hist_count = (state_q == DRAIN) ? rd_data : '0;
  assign hist.hist_last  = (state_q == DRAIN) && (idx_q == IDX_W'(BIN_N - 1));
  assign total           = total_q;
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_lbp_histogram.sv
// Directed test of lbp_histogram: accumulate, drain with stalls,
// saturation, frame-to-frame clearing and reset mid-drain.
module tb_lbp_histogram;

  logic        clk;
  logic        rst;
  logic        lbp_valid;
  logic [7:0]  lbp_data;
  logic        finish;
  logic [13:0] total;
  logic        done;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_finish;
  logic [3:0]  s_total;
  logic        s_done;

  int errors = 0;
  int checks = 0;
  int exp_bins [256];

  lbp_histogram_if #(.CNT_W(14)) hif ();
  lbp_histogram_if #(.CNT_W(4))  sif ();

  lbp_histogram #(.CNT_W(14)) dut (
    .clk       (clk),
    .reset     (rst),
    .lbp_valid (lbp_valid),
    .lbp_data  (lbp_data),
    .finish    (finish),
    .hist      (hif.master),
    .total     (total),
    .done      (done)
  );

  lbp_histogram #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .reset     (rst),
    .lbp_valid (s_valid),
    .lbp_data  (s_data),
    .finish    (s_finish),
    .hist      (sif.master),
    .total     (s_total),
    .done      (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_bins[i] = 0;
  endtask

  task automatic send_code(input logic [7:0] code);
    lbp_valid = 1'b1;
    lbp_data  = code;
    tick();
    lbp_valid = 1'b0;
  endtask

  // Drains stop_at beats, optionally stalling with ready pattern 1,0,0,1.
  task automatic drain_check(input int stop_at, input bit toggle);
    int  idx  = 0;
    int  xfer = 0;
    int  cyc  = 0;
    bit  rdy;
    while (idx < stop_at && cyc < 2000) begin
      rdy = toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      hif.hist_ready = rdy;
      check("drain_valid", hif.hist_valid, 1);
      check("drain_bin",   hif.hist_bin, idx);
      check("drain_count", hif.hist_count, exp_bins[idx]);
      check("drain_last",  hif.hist_last, (idx == 255));
      if (rdy) begin
        idx++;
        xfer++;
      end
      tick();
      cyc++;
    end
    hif.hist_ready = 1'b0;
    check("drain_xfers", xfer, stop_at);
    $display("drain: %0d transfers in %0d cycles (stall=%0d)", xfer, cyc, toggle);
  endtask

  task automatic end_frame();
    check("done_high", done, 1);
    check("done_valid_low", hif.hist_valid, 0);
    finish = 1'b0;
    tick();
    check("accum_done_low", done, 0);
    check("accum_total_clr", total, 0);
  endtask

  initial begin
    rst = 1'b1;
    lbp_valid = 1'b0; lbp_data = 8'h00; finish = 1'b1;
    s_valid = 1'b0; s_data = 8'h00; s_finish = 1'b0;
    hif.hist_ready = 1'b0;
    sif.hist_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", hif.hist_valid, 0);
    check("rst_bin",   hif.hist_bin, 0);
    check("rst_count", hif.hist_count, 0);
    check("rst_last",  hif.hist_last, 0);
    check("rst_total", total, 0);
    check("rst_done",  done, 0);
    rst = 1'b0;

    // finish high out of reset: no edge, codes ignored
    send_code(8'h10);
    send_code(8'h10);
    tick();
    check("fin_hi_total", total, 0);
    check("fin_hi_valid", hif.hist_valid, 0);
    check("fin_hi_done",  done, 0);
    $display("finish held from reset: total=%0d valid=%0d", total, hif.hist_valid);
    finish = 1'b0;
    tick();

    // Frame 1: 00,00,FF,00 back to back
    send_code(8'h00);
    send_code(8'h00);
    send_code(8'hFF);
    send_code(8'h00);
    check("f1_total", total, 4);
    finish = 1'b1;
    tick();
    clear_exp();
    exp_bins[0] = 3;
    exp_bins[255] = 1;
    check("f1_total_drain", total, 4);
    drain_check(256, 1'b0);
    end_frame();

    // Frame 2 without reset, stalled drain
    send_code(8'h07);
    send_code(8'h07);
    send_code(8'h07);
    check("f2_total", total, 3);
    finish = 1'b1;
    tick();
    clear_exp();
    exp_bins[7] = 3;
    drain_check(256, 1'b1);
    end_frame();

    // Full frame at upstream pacing: 126 rows of 126 codes, 2-cycle gap
    for (int r = 0; r < 126; r++) begin
      for (int c = 0; c < 126; c++) send_code(8'h5A);
      tick();
      tick();
    end
    check("full_total", total, 15876);
    finish = 1'b1;
    tick();
    clear_exp();
    exp_bins[8'h5A] = 15876;
    drain_check(256, 1'b0);
    end_frame();

    // Reset in the middle of a drain
    send_code(8'hC8);
    send_code(8'hC8);
    send_code(8'h03);
    finish = 1'b1;
    tick();
    clear_exp();
    exp_bins[3] = 1;
    exp_bins[8'hC8] = 2;
    drain_check(40, 1'b0);
    check("mid_bin40", hif.hist_bin, 40);
    rst = 1'b1;
    #1;
    check("mrst_valid", hif.hist_valid, 0);
    check("mrst_bin",   hif.hist_bin, 0);
    check("mrst_count", hif.hist_count, 0);
    check("mrst_last",  hif.hist_last, 0);
    check("mrst_total", total, 0);
    check("mrst_done",  done, 0);
    tick();
    rst = 1'b0;
    finish = 1'b0;
    tick();
    send_code(8'h28);
    send_code(8'h28);
    send_code(8'h01);
    finish = 1'b1;
    tick();
    clear_exp();
    exp_bins[8'h28] = 2;
    exp_bins[1] = 1;
    drain_check(256, 1'b0);
    end_frame();

    // Saturation with 4-bit counters
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h11;
      tick();
    end
    s_valid = 1'b0;
    check("sat_total", s_total, 15);
    s_finish = 1'b1;
    tick();
    sif.hist_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      check("sat_bin",   sif.hist_bin, i);
      check("sat_count", sif.hist_count, (i == 8'h11) ? 15 : 0);
      tick();
    end
    sif.hist_ready = 1'b0;
    check("sat_done", s_done, 1);
    check("sat_total_hold", s_total, 15);
    $display("saturation: total=%0d done=%0d", s_total, s_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lbp_histogram.md
# lbp_histogram

Downstream consumer of the LBP stage: accumulates a 256-bin histogram of the LBP codes produced for one 128x128 frame (126x126 interior pixels). After upstream `finish`, it drains the bins in order over a valid/ready stream. Each bin is cleared as it is drained, so the next frame needs no reset. The block has no backpressure toward the LBP stage; it accepts one code per cycle.

## Interface
- `CNT_W`, default 14: width of bin and total counters; 15876 interior pixels fit in 14 bits.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `lbp_valid`  in  1  LBP code strobe from the LBP stage.
- `lbp_data`  in  8  LBP code; the bin index.
- `finish`  in  1  level from the LBP stage; high once the frame is complete.
- `hist_valid`  out  1  drain beat valid.
- `hist_ready`  in  1  drain beat accepted by the consumer.
- `hist_bin`  out  8  bin index of the current beat.
- `hist_count`  out  CNT_W  count held in `hist_bin`.
- `hist_last`  out  1  high with the beat for bin 255.
- `total`  out  CNT_W  number of codes accepted this frame, saturating.
- `done`  out  1  high in DONE state.

## Operation
- Storage: 256 x `CNT_W` counters, all 0 after reset.
- States:
  - ACCUM, the reset state.
  - DRAIN.
  - DONE.
- ACCUM
  - A code is accepted when `lbp_valid && !finish`.
  - On acceptance, `bin[lbp_data]` increments and `total` increments.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Back-to-back codes in consecutive cycles are all counted, including the same code repeated; no update is lost.
  - A rising edge of `finish` (registered `finish_d` is 0, `finish` is 1) moves the state to DRAIN. The drain index is set to 0.
- DRAIN
  - `hist_valid` = 1, `hist_bin` = idx, `hist_count` = bin[idx], `hist_last` = (idx == 255).
  - Beat transfer: `hist_valid && hist_ready` at a clock edge.
  - On transfer, bin[idx] is cleared to 0 and idx increments.
  - The transfer with idx == 255 moves the state to DONE.
  - While `hist_ready` = 0, all `hist_*` outputs hold stable.
- DONE
  - `done` = 1 and `hist_valid` = 0.
  - When `finish` = 0, the state moves to ACCUM and `total` clears to 0.
- `lbp_valid` is ignored in DRAIN and DONE.
- `lbp_valid` is also ignored whenever `finish` = 1.
- Reset mid-operation, in any state: all counters, idx, `total` and outputs return to their reset values; the state returns to ACCUM.
- Reset values: `hist_valid` 0, `hist_bin` 0, `hist_count` 0, `hist_last` 0, `total` 0, `done` 0.

## Timing
- Accumulate latency is 1 cycle. A code accepted at edge N is visible in `bin[]` and `total` after edge N.
- DRAIN entry:
  - `finish` rises and is sampled at edge N; the state is DRAIN after edge N.
  - `hist_valid` is first high in the cycle following edge N.
- Drain throughput is 1 bin per cycle with `hist_ready` held high. The minimum drain is 256 cycles.
- `done` rises in the cycle after the bin-255 transfer.
- `lbp_valid` and a `finish` rising edge in the same cycle: the sample is dropped and the drain starts. This cannot occur with the LBP stage, which raises `finish` only after its last valid.
- `finish` held high from reset: there is no rising edge, so the block stays in ACCUM with nothing accepted.

## Structure
- Shared package `lbp_pkg` holds:
  - `CNT_W` default.
  - `BIN_N` = 256.
  - State enum {ACCUM, DRAIN, DONE}.
- Sub-module `lbp_hist_bank`, the counter array:
  - Asynchronous clear.
  - One saturating increment port.
  - One combinational read port with synchronous clear-on-read.
  - Simultaneous increment and clear are not possible, since the states are exclusive.
- The top level holds the FSM, `finish` edge register, drain index and `total`.

## Test plan
- Codes 0x00, 0x00, 0xFF, 0x00 back-to-back, then `finish` rises:
  - Drain shows bin0 = 3, bin255 = 1, all other bins 0.
  - `total` = 4.
  - `hist_last` is high only on bin 255.
  - `done` goes high afterwards.
- Full frame of 15876 codes of 0x5A at upstream pacing: bin 0x5A = 15876, `total` = 15876.
- Saturation with `CNT_W` = 4: 20 codes of 0x11 give bin 0x11 = 15 and `total` = 15.
- Drain with `hist_ready` toggling 1,0,0,1:
  - Outputs hold steady while stalled.
  - Exactly 256 transfers occur, in order 0..255.
- Second frame without reset: after DONE, `finish` drops, 3 codes of 0x07 arrive, then `finish` rises. Drain shows bin7 = 3 and every other bin 0, proving clear-on-drain.
- Reset asserted mid-DRAIN at bin 40:
  - All outputs return to 0 and the state returns to ACCUM.
  - A subsequent frame drains with fresh counts.
